// File: rtl/imm_decode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_decode_ctrl : decode-stage queue, immsel decoder and ID/EX register
// Revision        : 1.0
// ---------------------------------------------------------------------------
module imm_decode_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] gen_din,
  output logic [2:0]            gen_immsel,
  input  logic [DATA_WIDTH-1:0] gen_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_immsel,
  output logic                  out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [DATA_WIDTH-1:0] q_instr_q [2];
  logic [DATA_WIDTH-1:0] q_pc_q    [2];
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_instr_q, out_pc_q, out_imm_q;
  logic [2:0]            out_immsel_q;
  logic                  out_illegal_q;

  logic                  enq, deq, not_empty;
  logic [DATA_WIDTH-1:0] head_instr, head_pc;
  logic [2:0]            dec_immsel;
  logic                  dec_illegal;

  assign not_empty = (count_q != 2'd0);
  assign in_ready  = rst_n & (count_q != 2'd2);
  assign enq       = in_valid & in_ready;
  assign deq       = not_empty & (~out_valid_q | out_ready);

  assign head_instr = not_empty ? q_instr_q[rd_ptr_q] : '0;
  assign head_pc    = not_empty ? q_pc_q[rd_ptr_q]    : '0;

  always_comb begin
    dec_immsel  = 3'b000;
    dec_illegal = 1'b0;
    case (head_instr[6:0])
      OP_R: dec_immsel = 3'b000;
      OP_IMM: begin
        if (head_instr[14:12] == 3'b001)
          dec_immsel = 3'b001;
        else if (head_instr[14:12] == 3'b101)
          dec_immsel = head_instr[30] ? 3'b111 : 3'b001;
        else
          dec_immsel = 3'b010;
      end
      OP_LOAD, OP_JALR: dec_immsel = 3'b010;
      OP_STORE:         dec_immsel = 3'b011;
      OP_BRANCH:        dec_immsel = 3'b100;
      OP_JAL:           dec_immsel = 3'b101;
      OP_LUI, OP_AUIPC: dec_immsel = 3'b110;
      default:          dec_illegal = 1'b1;
    endcase
  end

  // The empty-queue case forces immsel to 000 even though opcode 0 decodes as illegal.
  assign gen_din    = head_instr;
  assign gen_immsel = not_empty ? dec_immsel : 3'b000;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q ^ deq;
    wr_ptr_d = wr_ptr_q ^ enq;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      q_instr_q[wr_ptr_q] <= in_instr;
      q_pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_imm_q     <= '0;
      out_immsel_q  <= 3'b000;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (deq) begin
        out_valid_q   <= 1'b1;
        out_instr_q   <= head_instr;
        out_pc_q      <= head_pc;
        out_imm_q     <= gen_dout;
        out_immsel_q  <= dec_immsel;
        out_illegal_q <= dec_illegal;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_imm_q;
  assign out_immsel  = out_immsel_q;
  assign out_illegal = out_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imm_decode_ctrl : directed scoreboard bench for imm_decode_ctrl
// Revision           : 1.0
// ---------------------------------------------------------------------------
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic [31:0] gen_din;
  logic [2:0]  gen_immsel;
  logic [31:0] gen_dout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [2:0]  out_immsel;
  logic        out_illegal;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  exp_t stim[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  logic [31:0] snap;

  always #5 clk = ~clk;

  function automatic logic [31:0] imm_gen(input logic [31:0] d, input logic [2:0] s);
    case (s)
      3'b001, 3'b111: return {27'b0, d[24:20]};
      3'b010:         return {{20{d[31]}}, d[31:20]};
      3'b011:         return {{20{d[31]}}, d[31:25], d[11:7]};
      3'b100:         return {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
      3'b101:         return {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
      3'b110:         return {d[31:12], 12'b0};
      default:        return 32'h0;
    endcase
  endfunction

  assign gen_dout = imm_gen(gen_din, gen_immsel);

  imm_decode_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .gen_din(gen_din), .gen_immsel(gen_immsel), .gen_dout(gen_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_immsel(out_immsel), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [31:0] i, input logic [31:0] p, input logic [2:0] s,
                     input logic [31:0] m, input logic l);
    exp_t e;
    e.instr = i; e.pc = p; e.sel = s; e.imm = m; e.ill = l;
    stim.push_back(e);
  endtask

  task automatic drive();
    if (stim.size() != 0) begin
      in_valid = 1'b1;
      in_instr = stim[0].instr;
      in_pc    = stim[0].pc;
    end else begin
      in_valid = 1'b0;
      in_instr = '0;
      in_pc    = '0;
    end
  endtask

  // One clock: compare whatever leaves the output register, then record what entered.
  task automatic tick();
    logic fire_in, fire_out, fl;
    exp_t e;
    fire_in  = in_valid & in_ready;
    fire_out = out_valid & out_ready;
    fl       = flush;
    if (fire_out && !fl) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", out_instr, 32'hxxxxxxxx);
      end else begin
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_pc", out_pc, e.pc);
        chk("out_imm", out_imm, e.imm);
        chk("out_immsel", {29'b0, out_immsel}, {29'b0, e.sel});
        chk("out_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
      end
    end
    @(posedge clk);
    #1;
    if (fire_in) begin
      acc_cnt++;
      e = stim.pop_front();
      if (!fl) sb.push_back(e);
    end
    if (fl) sb.delete();
    drive();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || stim.size() != 0); i++) tick();
    chk("drain_sb_empty", sb.size(), 32'd0);
    chk("drain_stim_empty", stim.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_gen_din", gen_din, 32'd0);
    chk("rst_gen_immsel", {29'b0, gen_immsel}, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: single addi, latency
    out_ready = 1'b1;
    add(32'hFFF00093, 32'h100, 3'b010, 32'hFFFFFFFF, 1'b0);
    drive();
    tick();
    chk("t1_gen_immsel", {29'b0, gen_immsel}, 32'd2);
    chk("t1_valid_early", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_out_imm", out_imm, 32'hFFFFFFFF);
    chk("t1_out_immsel", {29'b0, out_immsel}, 32'd2);
    chk("t1_out_illegal", {31'b0, out_illegal}, 32'd0);
    drain();

    // 2: back-to-back stream
    add(32'h00309093, 32'h200, 3'b001, 32'h00000003, 1'b0);
    add(32'h4030D093, 32'h204, 3'b111, 32'h00000003, 1'b0);
    add(32'hFE20AE23, 32'h208, 3'b011, 32'hFFFFFFFC, 1'b0);
    add(32'h0080006F, 32'h20C, 3'b101, 32'h00000008, 1'b0);
    drive();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_streak", {31'b0, out_valid}, 32'd1);
    end
    drain();

    // 3: output stall with fetch pushing 5 instructions
    out_ready = 1'b0;
    acc_cnt = 0;
    add(32'h00208463, 32'h300, 3'b100, 32'h00000008, 1'b0);
    add(32'h00001117, 32'h304, 3'b110, 32'h00001000, 1'b0);
    add(32'h00412083, 32'h308, 3'b010, 32'h00000004, 1'b0);
    add(32'h000080E7, 32'h30C, 3'b010, 32'h00000000, 1'b0);
    add(32'h0FF0F093, 32'h310, 3'b010, 32'h000000FF, 1'b0);
    drive();
    tick(); tick();
    snap = out_imm;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_accepted", acc_cnt, 32'd3);
    chk("t3_in_ready", {31'b0, in_ready}, 32'd0);
    chk("t3_out_instr", out_instr, 32'h00208463);
    chk("t3_out_imm_stable", out_imm, snap);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_nogap", {31'b0, out_valid}, 32'd1);
      tick();
    end
    drain();

    // 4: flush with a same-cycle handshake
    out_ready = 1'b0;
    add(32'h002081B3, 32'h400, 3'b000, 32'h00000000, 1'b0);
    add(32'h00309093, 32'h404, 3'b001, 32'h00000003, 1'b0);
    add(32'hDEAD0037, 32'h408, 3'b110, 32'hDEAD0000, 1'b0);
    drive();
    tick(); tick();
    chk("t4_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_pre_in_ready", {31'b0, in_ready}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_empty_din", gen_din, 32'd0);
    chk("t4_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_stale", {31'b0, out_valid}, 32'd0);
    end

    // 5: illegal opcode then lui
    add(32'h0000007F, 32'h500, 3'b000, 32'h00000000, 1'b1);
    add(32'h12345037, 32'h504, 3'b110, 32'h12345000, 1'b0);
    drive();
    drain();

    // 6: async reset with a full queue
    out_ready = 1'b0;
    add(32'h00100093, 32'h600, 3'b010, 32'h00000001, 1'b0);
    add(32'h00200093, 32'h604, 3'b010, 32'h00000002, 1'b0);
    add(32'h00300093, 32'h608, 3'b010, 32'h00000003, 1'b0);
    drive();
    tick(); tick(); tick();
    chk("t6_full", {31'b0, in_ready}, 32'd0);
    chk("t6_valid_before", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_async_in_ready", {31'b0, in_ready}, 32'd0);
    sb.delete();
    stim.delete();
    drive();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_stale", {31'b0, out_valid}, 32'd0);
    end
    add(32'h12345037, 32'h700, 3'b110, 32'h12345000, 1'b0);
    drive();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
